apb_master_bridge: RTL and testbench

//  Parametrised APB4 master: accepts one command at a time on a valid/ready request port and

---
 rtl/apb_master_bridge.sv | 218 +++++++++++++++++++++
 tb/tb_apb_master_bridge.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command port to multi-slave APB4 master.
// Ports: pclk/presetn; cmd_* request in; rsp_* response out; APB4 bus (psel one-hot per slave).
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
  localparam int STRB_W = DATA_WIDTH / 8
) (
  input  logic                             pclk,
  input  logic                             presetn,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [SEL_W-1:0]                 cmd_sel,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [DATA_WIDTH-1:0]            cmd_wdata,
  input  logic [STRB_W-1:0]                cmd_strb,
  input  logic [2:0]                       cmd_prot,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_slverr,
  output logic                             rsp_timeout,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [STRB_W-1:0]                pstrb,
  output logic [2:0]                       pprot,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr
);

  localparam int CNT_W =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [SEL_W:0] LP_NS = (SEL_W + 1)'(NUM_SLAVES);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t r_state, w_state_n;

  logic                  r_run;
  logic [SEL_W-1:0]      r_sel, w_sel_n;
  logic [CNT_W-1:0]      r_cnt, w_cnt_n;
  logic [NUM_SLAVES-1:0] r_psel, w_psel_n;
  logic                  r_penable, w_penable_n;
  logic                  r_pwrite, w_pwrite_n;
  logic [ADDR_WIDTH-1:0] r_paddr, w_paddr_n;
  logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata_n;
  logic [STRB_W-1:0]     r_pstrb, w_pstrb_n;
  logic [2:0]            r_pprot, w_pprot_n;
  logic                  r_rsp_valid, w_rsp_valid_n;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_n;
  logic                  r_rsp_slverr, w_rsp_slverr_n;
  logic                  r_rsp_timeout, w_rsp_timeout_n;

  logic                  w_pready;
  logic                  w_pslverr;
  logic [DATA_WIDTH-1:0] w_prdata;
  logic                  w_cmd_ready;
  logic                  w_accept;
  logic                  w_bad_sel;
  logic                  w_limit;

  always_comb begin
    w_pready  = 1'b0;
    w_pslverr = 1'b0;
    w_prdata  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_sel == SEL_W'(i)) begin
        w_pready  = pready[i];
        w_pslverr = pslverr[i];
        w_prdata  = prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // r_run keeps cmd_ready low while presetn is asserted.
  assign w_cmd_ready = r_run && (r_state == S_IDLE)
                    && (!r_rsp_valid || rsp_ready);
  assign w_accept    = cmd_valid && w_cmd_ready;
  assign w_bad_sel   = ({1'b0, cmd_sel} >= LP_NS);
  assign w_limit     = (TIMEOUT_CYCLES > 0) && (r_cnt == LP_LAST);

  always_comb begin
    w_state_n       = r_state;
    w_sel_n         = r_sel;
    w_cnt_n         = r_cnt;
    w_psel_n        = r_psel;
    w_penable_n     = r_penable;
    w_pwrite_n      = r_pwrite;
    w_paddr_n       = r_paddr;
    w_pwdata_n      = r_pwdata;
    w_pstrb_n       = r_pstrb;
    w_pprot_n       = r_pprot;
    w_rsp_valid_n   = r_rsp_valid;
    w_rsp_rdata_n   = r_rsp_rdata;
    w_rsp_slverr_n  = r_rsp_slverr;
    w_rsp_timeout_n = r_rsp_timeout;

    if (r_rsp_valid && rsp_ready) begin
      w_rsp_valid_n = 1'b0;
    end

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_sel_n = cmd_sel;
          if (w_bad_sel) begin
            w_rsp_valid_n   = 1'b1;
            w_rsp_rdata_n   = '0;
            w_rsp_slverr_n  = 1'b1;
            w_rsp_timeout_n = 1'b0;
          end else begin
            w_state_n  = S_SETUP;
            w_pwrite_n = cmd_write;
            w_paddr_n  = cmd_addr;
            w_pwdata_n = cmd_wdata;
            w_pstrb_n  = cmd_write ? cmd_strb : '0;
            w_pprot_n  = cmd_prot;
            for (int i = 0; i < NUM_SLAVES; i++) begin
              w_psel_n[i] = (cmd_sel == SEL_W'(i));
            end
          end
        end
      end
      S_SETUP: begin
        w_state_n   = S_ACCESS;
        w_penable_n = 1'b1;
        w_cnt_n     = '0;
      end
      S_ACCESS: begin
        // pready wins over a timeout landing on the same cycle.
        if (w_pready) begin
          w_state_n       = S_IDLE;
          w_psel_n        = '0;
          w_penable_n     = 1'b0;
          w_rsp_valid_n   = 1'b1;
          w_rsp_rdata_n   = r_pwrite ? '0 : w_prdata;
          w_rsp_slverr_n  = w_pslverr;
          w_rsp_timeout_n = 1'b0;
        end else if (w_limit) begin
          w_state_n       = S_IDLE;
          w_psel_n        = '0;
          w_penable_n     = 1'b0;
          w_rsp_valid_n   = 1'b1;
          w_rsp_rdata_n   = '0;
          w_rsp_slverr_n  = 1'b1;
          w_rsp_timeout_n = 1'b1;
        end else if (TIMEOUT_CYCLES > 0) begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state       <= S_IDLE;
      r_run         <= 1'b0;
      r_sel         <= '0;
      r_cnt         <= '0;
      r_psel        <= '0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_pprot       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_slverr  <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_run         <= 1'b1;
      r_sel         <= w_sel_n;
      r_cnt         <= w_cnt_n;
      r_psel        <= w_psel_n;
      r_penable     <= w_penable_n;
      r_pwrite      <= w_pwrite_n;
      r_paddr       <= w_paddr_n;
      r_pwdata      <= w_pwdata_n;
      r_pstrb       <= w_pstrb_n;
      r_pprot       <= w_pprot_n;
      r_rsp_valid   <= w_rsp_valid_n;
      r_rsp_rdata   <= w_rsp_rdata_n;
      r_rsp_slverr  <= w_rsp_slverr_n;
      r_rsp_timeout <= w_rsp_timeout_n;
    end
  end

  assign cmd_ready   = w_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_slverr  = r_rsp_slverr;
  assign rsp_timeout = r_rsp_timeout;
  assign psel        = r_psel;
  assign penable     = r_penable;
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign pstrb       = r_pstrb;
  assign pprot       = r_pprot;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed bench for apb_master_bridge.
// Main DUT has 4 slaves; a 3-slave instance covers the decode-error path.
module tb_apb_master_bridge;

  logic        pclk;
  logic        presetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [1:0]  cmd_sel;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [3:0]  psel;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [127:0] prdata;
  logic [3:0]  pready, pslverr;

  logic        cmd_valid3, cmd_ready3;
  logic        rsp_valid3, rsp_ready3, rsp_slverr3, rsp_timeout3;
  logic [31:0] rsp_rdata3;
  logic [2:0]  psel3;
  logic        penable3, pwrite3;
  logic [31:0] paddr3, pwdata3;
  logic [3:0]  pstrb3;
  logic [2:0]  pprot3;
  logic [95:0] prdata3;
  logic [2:0]  pready3, pslverr3;

  int n_chk;
  int n_fail;

  apb_master_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .NUM_SLAVES(4), .TIMEOUT_CYCLES(16)
  ) u_dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_sel(cmd_sel),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pprot(pprot), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  apb_master_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .NUM_SLAVES(3), .TIMEOUT_CYCLES(16)
  ) u_dut3 (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_write(cmd_write), .cmd_sel(cmd_sel),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_rdata(rsp_rdata3), .rsp_slverr(rsp_slverr3),
    .rsp_timeout(rsp_timeout3),
    .psel(psel3), .penable(penable3), .pwrite(pwrite3),
    .paddr(paddr3), .pwdata(pwdata3), .pstrb(pstrb3),
    .pprot(pprot3), .prdata(prdata3), .pready(pready3),
    .pslverr(pslverr3)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_cmd(input logic w, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] st);
    cmd_write = w;
    cmd_sel   = s;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = st;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    presetn = 1'b0;
    cmd_valid = 1'b0;
    cmd_prot = 3'b000;
    set_cmd(1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    rsp_ready = 1'b1;
    prdata = '0;
    pready = 4'hF;
    pslverr = 4'h0;
    cmd_valid3 = 1'b0;
    rsp_ready3 = 1'b1;
    prdata3 = '0;
    pready3 = 3'b111;
    pslverr3 = 3'b000;

    // reset state
    #3;
    chk("rst_psel", psel, 4'h0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    repeat (2) tick();
    chk("rst_penable", penable, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwrite", pwrite, 1'b0);
    chk("rst_cmd_ready3", cmd_ready3, 1'b0);
    presetn = 1'b1;
    tick();
    chk("run_cmd_ready", cmd_ready, 1'b1);

    // 1: zero-wait write, sel=2, unselected pslverr ignored
    pslverr = 4'b1011;
    cmd_prot = 3'b010;
    set_cmd(1'b1, 2'd2, 32'h104, 32'hA5A5_0F0F, 4'hF);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("t1_setup_psel", psel, 4'b0100);
    chk("t1_setup_penable", penable, 1'b0);
    chk("t1_paddr", paddr, 32'h104);
    chk("t1_pwdata", pwdata, 32'hA5A5_0F0F);
    chk("t1_pstrb", pstrb, 4'hF);
    chk("t1_pwrite", pwrite, 1'b1);
    chk("t1_pprot", pprot, 3'b010);
    chk("t1_cmd_ready_busy", cmd_ready, 1'b0);
    tick();
    chk("t1_access_psel", psel, 4'b0100);
    chk("t1_access_penable", penable, 1'b1);
    chk("t1_access_rsp_valid", rsp_valid, 1'b0);
    tick();
    chk("t1_rsp_valid", rsp_valid, 1'b1);
    chk("t1_rsp_slverr", rsp_slverr, 1'b0);
    chk("t1_rsp_timeout", rsp_timeout, 1'b0);
    chk("t1_rsp_rdata", rsp_rdata, 32'h0);
    chk("t1_idle_psel", psel, 4'h0);
    chk("t1_idle_penable", penable, 1'b0);
    tick();
    chk("t1_rsp_consumed", rsp_valid, 1'b0);
    pslverr = 4'h0;

    // 2: read sel=0 with 3 wait states
    prdata = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'h1234_5678};
    pready = 4'b1110;
    set_cmd(1'b0, 2'd0, 32'h20, 32'h55, 4'hF);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("t2_setup_psel", psel, 4'b0001);
    chk("t2_pstrb", pstrb, 4'h0);
    chk("t2_pwrite", pwrite, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_wait_penable", penable, 1'b1);
      chk("t2_wait_paddr", paddr, 32'h20);
      chk("t2_wait_rsp_valid", rsp_valid, 1'b0);
    end
    tick();
    chk("t2_access4_penable", penable, 1'b1);
    pready = 4'hF;
    tick();
    chk("t2_rsp_valid", rsp_valid, 1'b1);
    chk("t2_rsp_rdata", rsp_rdata, 32'h1234_5678);
    chk("t2_rsp_slverr", rsp_slverr, 1'b0);
    chk("t2_psel", psel, 4'h0);
    tick();

    // 3: write with slave error
    pslverr = 4'b0010;
    set_cmd(1'b1, 2'd1, 32'h40, 32'h11, 4'b0011);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("t3_setup_psel", psel, 4'b0010);
    chk("t3_pstrb", pstrb, 4'b0011);
    repeat (2) tick();
    chk("t3_rsp_valid", rsp_valid, 1'b1);
    chk("t3_rsp_slverr", rsp_slverr, 1'b1);
    chk("t3_rsp_timeout", rsp_timeout, 1'b0);
    chk("t3_rsp_rdata", rsp_rdata, 32'h0);
    tick();
    pslverr = 4'h0;

    // 4a: timeout after 16 ACCESS cycles
    pready = 4'b0111;
    set_cmd(1'b0, 2'd3, 32'h80, 32'h0, 4'hF);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (16) tick();
    chk("t4a_access16_penable", penable, 1'b1);
    chk("t4a_access16_psel", psel, 4'b1000);
    chk("t4a_access16_rsp", rsp_valid, 1'b0);
    tick();
    chk("t4a_psel", psel, 4'h0);
    chk("t4a_penable", penable, 1'b0);
    chk("t4a_rsp_valid", rsp_valid, 1'b1);
    chk("t4a_rsp_slverr", rsp_slverr, 1'b1);
    chk("t4a_rsp_timeout", rsp_timeout, 1'b1);
    chk("t4a_rsp_rdata", rsp_rdata, 32'h0);
    tick();

    // 4b: pready on the 16th ACCESS cycle completes normally
    prdata[127:96] = 32'hCAFE_BABE;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (16) tick();
    chk("t4b_access16_penable", penable, 1'b1);
    pready = 4'hF;
    tick();
    chk("t4b_rsp_valid", rsp_valid, 1'b1);
    chk("t4b_rsp_slverr", rsp_slverr, 1'b0);
    chk("t4b_rsp_timeout", rsp_timeout, 1'b0);
    chk("t4b_rsp_rdata", rsp_rdata, 32'hCAFE_BABE);
    tick();

    // 5: decode error on 3-slave instance
    set_cmd(1'b1, 2'd3, 32'h0, 32'h77, 4'hF);
    cmd_valid3 = 1'b1;
    chk("t5_cmd_ready3", cmd_ready3, 1'b1);
    tick();
    cmd_valid3 = 1'b0;
    chk("t5_psel3", psel3, 3'b000);
    chk("t5_penable3", penable3, 1'b0);
    chk("t5_rsp_valid3", rsp_valid3, 1'b1);
    chk("t5_rsp_slverr3", rsp_slverr3, 1'b1);
    chk("t5_rsp_timeout3", rsp_timeout3, 1'b0);
    chk("t5_rsp_rdata3", rsp_rdata3, 32'h0);
    tick();
    chk("t5_rsp_consumed3", rsp_valid3, 1'b0);
    chk("t5_main_idle", psel, 4'h0);

    // 6: backpressure then async reset mid-ACCESS
    rsp_ready = 1'b0;
    set_cmd(1'b1, 2'd0, 32'h10, 32'hBEEF, 4'hF);
    cmd_valid = 1'b1;
    repeat (3) tick();
    chk("t6_rsp_valid", rsp_valid, 1'b1);
    chk("t6_cmd_ready", cmd_ready, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t6_hold_cmd_ready", cmd_ready, 1'b0);
      chk("t6_hold_rsp_valid", rsp_valid, 1'b1);
      chk("t6_hold_slverr", rsp_slverr, 1'b0);
      chk("t6_hold_psel", psel, 4'h0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("t6_release_cmd_ready", cmd_ready, 1'b1);
    tick();
    chk("t6_next_setup_psel", psel, 4'b0001);
    chk("t6_next_rsp_valid", rsp_valid, 1'b0);
    cmd_valid = 1'b0;
    tick();
    chk("t6_access_penable", penable, 1'b1);
    #2;
    presetn = 1'b0;
    #1;
    chk("t6_arst_psel", psel, 4'h0);
    chk("t6_arst_penable", penable, 1'b0);
    chk("t6_arst_cmd_ready", cmd_ready, 1'b0);
    chk("t6_arst_rsp_valid", rsp_valid, 1'b0);
    chk("t6_arst_paddr", paddr, 32'h0);
    chk("t6_arst_pwdata", pwdata, 32'h0);
    chk("t6_arst_pstrb", pstrb, 4'h0);
    chk("t6_arst_pwrite", pwrite, 1'b0);
    tick();
    presetn = 1'b1;
    tick();
    chk("t6_post_cmd_ready", cmd_ready, 1'b1);
    chk("t6_post_rsp_valid", rsp_valid, 1'b0);
    chk("t6_post_psel", psel, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
